// File: rtl/conv_scheduler.sv
// Frame sequencer for the convolve datapath: walks every valid output position,
// streams window/kernel tap addresses, waits for the convolve result and writes it out.
module conv_scheduler #(
    parameter int KERNEL_SIZE     = 3,
    parameter int DATA_WIDTH      = 8,
    parameter int IMG_WIDTH       = 4,
    parameter int IMG_HEIGHT      = 4,
    parameter int SRAM_ADDR_WIDTH = 4,
    parameter int KADDR_WIDTH     = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_frame_done,
    output logic                       o_conv_start,
    output logic                       o_win_valid,
    output logic [SRAM_ADDR_WIDTH-1:0] o_win_addr,
    output logic [KADDR_WIDTH-1:0]     o_kern_addr,
    input  logic                       i_conv_done,
    input  logic [DATA_WIDTH-1:0]      i_conv_result,
    output logic                       o_out_we,
    output logic [SRAM_ADDR_WIDTH-1:0] o_out_addr,
    output logic [DATA_WIDTH-1:0]      o_out_data
);

    localparam int AW    = SRAM_ADDR_WIDTH;
    localparam int KW    = KADDR_WIDTH;
    localparam int OUT_W = IMG_WIDTH - KERNEL_SIZE + 1;
    localparam int OUT_H = IMG_HEIGHT - KERNEL_SIZE + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [KW-1:0] TAP_LAST = KW'(KERNEL_SIZE * KERNEL_SIZE - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(KERNEL_SIZE - 1);
    localparam logic [AW-1:0] COL_LAST = AW'(OUT_W - 1);
    localparam logic [AW-1:0] ROW_LAST = AW'(OUT_H - 1);

    logic [2:0]            state_r, state_s;
    logic [AW-1:0]         row_r, row_s, col_r, col_s;
    logic [KW-1:0]         tap_r, tap_s, kr_r, kr_s, kc_r, kc_s;
    logic [DATA_WIDTH-1:0] result_r, result_s;

    logic                  busy_s, frame_done_s, conv_start_s, win_valid_s, out_we_s;
    logic [AW-1:0]         win_addr_s, out_addr_s;
    logic [KW-1:0]         kern_addr_s;
    logic [DATA_WIDTH-1:0] out_data_s;

    function automatic logic [AW-1:0] win_addr_f(input logic [AW-1:0] row, input logic [AW-1:0] col,
                                                 input logic [KW-1:0] kr, input logic [KW-1:0] kc);
        logic [AW-1:0] kr_ext;
        logic [AW-1:0] kc_ext;
        kr_ext = AW'(kr);
        kc_ext = AW'(kc);
        return (row + kr_ext) * AW'(IMG_WIDTH) + col + kc_ext;
    endfunction

    function automatic logic [AW-1:0] out_addr_f(input logic [AW-1:0] row, input logic [AW-1:0] col);
        return row * AW'(OUT_W) + col;
    endfunction

    // Next-state and counter update; taps walk kc fastest, kr on kc wrap.
    always_comb begin
        state_s  = state_r;
        row_s    = row_r;
        col_s    = col_r;
        tap_s    = tap_r;
        kr_s     = kr_r;
        kc_s     = kc_r;
        result_s = result_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_s = ST_ISSUE;
                    row_s   = {AW{1'b0}};
                    col_s   = {AW{1'b0}};
                    tap_s   = {KW{1'b0}};
                    kr_s    = {KW{1'b0}};
                    kc_s    = {KW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (tap_r == TAP_LAST) begin
                    state_s = ST_WAIT;
                    tap_s   = {KW{1'b0}};
                    kr_s    = {KW{1'b0}};
                    kc_s    = {KW{1'b0}};
                end else if (kc_r == K_LAST) begin
                    tap_s = tap_r + {{(KW-1){1'b0}}, 1'b1};
                    kc_s  = {KW{1'b0}};
                    kr_s  = kr_r + {{(KW-1){1'b0}}, 1'b1};
                end else begin
                    tap_s = tap_r + {{(KW-1){1'b0}}, 1'b1};
                    kc_s  = kc_r + {{(KW-1){1'b0}}, 1'b1};
                end
            end
            ST_WAIT: begin
                if (i_conv_done) begin
                    state_s  = ST_WRITE;
                    result_s = i_conv_result;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WRITE: begin
                if ((row_r == ROW_LAST) && (col_r == COL_LAST)) begin
                    state_s = ST_DONE;
                    row_s   = {AW{1'b0}};
                    col_s   = {AW{1'b0}};
                end else if (col_r == COL_LAST) begin
                    state_s = ST_ISSUE;
                    col_s   = {AW{1'b0}};
                    row_s   = row_r + {{(AW-1){1'b0}}, 1'b1};
                end else begin
                    state_s = ST_ISSUE;
                    col_s   = col_r + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the upcoming state, so registered outputs line up with that state.
    always_comb begin
        busy_s       = (state_s != ST_IDLE);
        frame_done_s = (state_s == ST_DONE);
        win_valid_s  = (state_s == ST_ISSUE);
        out_we_s     = (state_s == ST_WRITE);
        if (state_s == ST_ISSUE) begin
            conv_start_s = (tap_s == {KW{1'b0}});
            win_addr_s   = win_addr_f(row_s, col_s, kr_s, kc_s);
            kern_addr_s  = tap_s;
        end else begin
            conv_start_s = 1'b0;
            win_addr_s   = {AW{1'b0}};
            kern_addr_s  = {KW{1'b0}};
        end
        if (state_s == ST_WRITE) begin
            out_addr_s = out_addr_f(row_s, col_s);
            out_data_s = result_s;
        end else begin
            out_addr_s = {AW{1'b0}};
            out_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // State, counters and output registers; reset aborts any frame in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            row_r        <= {AW{1'b0}};
            col_r        <= {AW{1'b0}};
            tap_r        <= {KW{1'b0}};
            kr_r         <= {KW{1'b0}};
            kc_r         <= {KW{1'b0}};
            result_r     <= {DATA_WIDTH{1'b0}};
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_conv_start <= 1'b0;
            o_win_valid  <= 1'b0;
            o_win_addr   <= {AW{1'b0}};
            o_kern_addr  <= {KW{1'b0}};
            o_out_we     <= 1'b0;
            o_out_addr   <= {AW{1'b0}};
            o_out_data   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r      <= state_s;
            row_r        <= row_s;
            col_r        <= col_s;
            tap_r        <= tap_s;
            kr_r         <= kr_s;
            kc_r         <= kc_s;
            result_r     <= result_s;
            o_busy       <= busy_s;
            o_frame_done <= frame_done_s;
            o_conv_start <= conv_start_s;
            o_win_valid  <= win_valid_s;
            o_win_addr   <= win_addr_s;
            o_kern_addr  <= kern_addr_s;
            o_out_we     <= out_we_s;
            o_out_addr   <= out_addr_s;
            o_out_data   <= out_data_s;
        end
    end

endmodule

// File: tb/tb_conv_scheduler.sv
// Scoreboard bench for conv_scheduler (4x4 map, 3x3 kernel, 2x2 output).
module tb_conv_scheduler;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_conv_start;
    logic       o_win_valid;
    logic [3:0] o_win_addr;
    logic [3:0] o_kern_addr;
    logic       i_conv_done;
    logic [7:0] i_conv_result;
    logic       o_out_we;
    logic [3:0] o_out_addr;
    logic [7:0] o_out_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  win_q[$];
    logic [11:0] wr_q[$];
    int          fd_q[$];
    logic [7:0]  mon_tap;
    logic [11:0] mon_wr;
    int          mon_fd;

    conv_scheduler #(
        .KERNEL_SIZE(3), .DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4),
        .SRAM_ADDR_WIDTH(4), .KADDR_WIDTH(4)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .o_busy(o_busy),
        .o_frame_done(o_frame_done), .o_conv_start(o_conv_start), .o_win_valid(o_win_valid),
        .o_win_addr(o_win_addr), .o_kern_addr(o_kern_addr), .i_conv_done(i_conv_done),
        .i_conv_result(i_conv_result), .o_out_we(o_out_we), .o_out_addr(o_out_addr),
        .o_out_data(o_out_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({o_busy, o_frame_done, o_conv_start, o_win_valid, o_win_addr, o_kern_addr,
                    o_out_we, o_out_addr, o_out_data});
    endfunction

    // Scoreboard consumer: every tap, write and frame_done must match the next expectation.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_win_valid) begin
                if (win_q.size() == 0) begin
                    check("unexpected_tap", 32'd1, 32'd0);
                end else begin
                    mon_tap = win_q.pop_front();
                    check("win_addr", 32'(o_win_addr), 32'(mon_tap[7:4]));
                    check("kern_addr", 32'(o_kern_addr), 32'(mon_tap[3:0]));
                    check("conv_start", 32'(o_conv_start), 32'(mon_tap[3:0] == 4'd0));
                end
            end else if (o_conv_start) begin
                check("stray_conv_start", 32'd1, 32'd0);
            end
            if (o_out_we) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'(o_out_addr), 32'hFFFF);
                end else begin
                    mon_wr = wr_q.pop_front();
                    check("out_addr", 32'(o_out_addr), 32'(mon_wr[11:8]));
                    check("out_data", 32'(o_out_data), 32'(mon_wr[7:0]));
                end
            end
            if (o_frame_done) begin
                if (fd_q.size() == 0) begin
                    check("unexpected_frame_done", 32'd1, 32'd0);
                end else begin
                    mon_fd = fd_q.pop_front();
                    check("frame_done_busy", 32'(o_busy), 32'(mon_fd));
                end
            end
        end
    end

    // One frame; caller is at a negedge with the DUT idle. Optional stall, spurious pulses, or abort.
    task automatic run_frame(input int stall_pos, input int stall_cyc, input int spur_pos, input int rst_pos);
        int cyc;
        int t;
        int last;
        int extra;
        logic [3:0] a;
        last  = (rst_pos >= 0) ? rst_pos : 3;
        extra = (stall_pos >= 0) ? stall_cyc : 0;
        for (int p = 0; p <= last; p++) begin
            for (int k = 0; k < 9; k++) begin
                a = 4'(((p / 2) + k / 3) * 4 + (p % 2) + k % 3);
                win_q.push_back({a, 4'(k)});
            end
            if (p != rst_pos) wr_q.push_back({4'(p), 8'(8'h10 + p)});
        end
        if (rst_pos < 0) fd_q.push_back(1);
        i_start = 1'b1;
        cyc = 0;
        @(negedge i_clk);
        cyc++;
        i_start = 1'b0;
        for (int p = 0; p < 4; p++) begin
            t = 0;
            while (!o_conv_start && t < 50) begin
                @(negedge i_clk);
                t++;
                cyc++;
            end
            check("conv_start_seen", 32'(o_conv_start), 32'd1);
            t = 0;
            while (o_win_valid && t < 50) begin
                if (p == spur_pos && t == 3) begin
                    i_start     = 1'b1;
                    i_conv_done = 1'b1;
                end else begin
                    i_start     = 1'b0;
                    i_conv_done = 1'b0;
                end
                @(negedge i_clk);
                t++;
                cyc++;
            end
            i_start     = 1'b0;
            i_conv_done = 1'b0;
            check("issue_len", 32'(t), 32'd9);
            if (p == rst_pos) begin
                i_rst = 1'b1;
                #1;
                check("abort_outputs_zero", all_outs(), 32'd0);
                check("abort_pending_writes", 32'(wr_q.size()), 32'd0);
                check("abort_pending_taps", 32'(win_q.size()), 32'd0);
                @(negedge i_clk);
                @(negedge i_clk);
                i_rst = 1'b0;
                @(negedge i_clk);
                check("abort_idle", all_outs(), 32'd0);
                return;
            end
            if (p == stall_pos) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    check("stall_no_write", 32'(o_out_we), 32'd0);
                    check("stall_no_addr", 32'({o_win_valid, o_win_addr}), 32'd0);
                    @(negedge i_clk);
                    cyc++;
                end
            end
            i_conv_result = 8'(8'h10 + p);
            i_conv_done   = 1'b1;
            @(negedge i_clk);
            cyc++;
            i_conv_done = 1'b0;
            check("write_after_done", 32'(o_out_we), 32'd1);
        end
        @(negedge i_clk);
        cyc++;
        check("frame_done_pulse", 32'(o_frame_done), 32'd1);
        check("frame_len", 32'(cyc), 32'(45 + extra));
    endtask

    initial begin
        i_rst         = 1'b1;
        i_start       = 1'b0;
        i_conv_done   = 1'b0;
        i_conv_result = 8'h00;
        repeat (3) @(negedge i_clk);
        check("reset_outputs", all_outs(), 32'd0);
        i_rst       = 1'b0;
        i_conv_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("idle_no_activity", all_outs(), 32'd0);
        end
        i_conv_done = 1'b0;
        @(negedge i_clk);

        run_frame(-1, 0, -1, -1);
        @(negedge i_clk);
        check("idle_after_frame", 32'(o_busy), 32'd0);
        run_frame(1, 5, -1, -1);
        @(negedge i_clk);
        run_frame(-1, 0, 2, -1);
        @(negedge i_clk);
        run_frame(-1, 0, -1, 2);
        run_frame(-1, 0, -1, -1);
        @(negedge i_clk);
        run_frame(-1, 0, -1, -1);
        @(negedge i_clk);
        run_frame(-1, 0, -1, -1);
        repeat (3) @(negedge i_clk);

        check("taps_left", 32'(win_q.size()), 32'd0);
        check("writes_left", 32'(wr_q.size()), 32'd0);
        check("frame_dones_left", 32'(fd_q.size()), 32'd0);
        check("final_idle", 32'(o_busy), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
